exercise_burst_feeder: RTL

- Upstream stage that feeds the exercise core, which accepts 6-word in_valid bursts with in_mode on the first beat.
- Accepts a free-running valid/ready stream of 9-bit words plus mode and packs them into 6-word groups in a ping-pong buffer.
- Issues one group per core transaction, waits for the core's out_valid burst to complete, then enforces an inter-burst gap.

---
 rtl/exercise_burst_feeder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/exercise_burst_feeder.sv
// rtl/exercise_burst_feeder.sv - packs a word stream into 6-word ping-pong groups and issues them as core bursts
//
// Purpose: accepts a valid/ready stream of 9-bit words plus a 3-bit mode and
// packs them into groups of GROUP words across two banks. Each full bank is
// issued to the core as one GROUP-beat in_valid burst. The feeder then waits
// for the core's out_valid burst to complete (or time out) and holds an idle
// gap before the next burst.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous reset, active-high (1 clears state)
//   s_valid     upstream word valid
//   s_data      upstream word (9b)
//   s_mode      group mode (3b), sampled with the first word of a group
//   s_ready     feeder can take s_data this cycle
//   in_valid    burst valid to core
//   in_data     burst word to core (9b)
//   in_mode     mode to core, nonzero only on the first beat
//   out_valid   core output valid, observed only
//   busy        FSM not idle or any buffered data present
//   timeout_err sticky flag: core never answered a burst
//   grp_cnt     completed transactions, modulo 2^16
module exercise_burst_feeder #(
  parameter int GROUP   = 6,
  parameter int MIN_GAP = 2,
  parameter int TIMEOUT = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [8:0]  s_data,
  input  logic [2:0]  s_mode,
  output logic        s_ready,
  output logic        in_valid,
  output logic [8:0]  in_data,
  output logic [2:0]  in_mode,
  input  logic        out_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] grp_cnt
);

  localparam int IW = $clog2(GROUP);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(MIN_GAP + 2);

  localparam logic [IW-1:0] LAST_IDX = IW'(GROUP - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [GW-1:0] GAP_INIT = GW'(MIN_GAP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_GAP
  } state_t;

  // Storage: two banks of GROUP words, one mode register per bank.
  logic [8:0]    bank_q [2][GROUP];
  logic [2:0]    mode_q [2];

  logic [1:0]    full_q, full_d;
  logic          fill_ptr_q, fill_ptr_d;
  logic [IW-1:0] fill_idx_q, fill_idx_d;
  logic          iss_ptr_q, iss_ptr_d;

  state_t        state_q, state_d;
  logic [IW-1:0] beat_q, beat_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;
  logic [15:0]   grp_q, grp_d;

  logic          fill_acc;
  logic          fill_done;
  logic          free_iss;

  // s_ready is forced low while reset is asserted so nothing is accepted
  // into a bank that is being cleared.
  assign s_ready   = ~rst_n & ~full_q[fill_ptr_q];
  assign fill_acc  = s_valid & s_ready;
  assign fill_done = fill_acc & (fill_idx_q == LAST_IDX);

  always_comb begin
    full_d     = full_q;
    fill_ptr_d = fill_ptr_q;
    fill_idx_d = fill_idx_q;
    if (fill_acc) begin
      if (fill_done) begin
        fill_idx_d = '0;
        fill_ptr_d = ~fill_ptr_q;
        full_d[fill_ptr_q] = 1'b1;
      end else begin
        fill_idx_d = fill_idx_q + 1'b1;
      end
    end
    // The bank being freed is never the bank being filled: a full bank
    // blocks s_ready, so both updates can coexist.
    if (free_iss) begin
      full_d[iss_ptr_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_acc) begin
      bank_q[fill_ptr_q][fill_idx_q] <= s_data;
      if (fill_idx_q == '0) begin
        mode_q[fill_ptr_q] <= s_mode;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tcnt_d    = tcnt_q;
    gap_d     = gap_q;
    err_d     = err_q;
    grp_d     = grp_q;
    iss_ptr_d = iss_ptr_q;
    free_iss  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Looking at the completing fill lets the first beat appear the
        // cycle right after the last word is accepted.
        if (full_q[iss_ptr_q] || (fill_done && (fill_ptr_q == iss_ptr_q))) begin
          state_d = ST_ISSUE;
          beat_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (beat_q == LAST_IDX) begin
          free_iss  = 1'b1;
          iss_ptr_d = ~iss_ptr_q;
          tcnt_d    = '0;
          state_d   = ST_WAIT_RISE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (out_valid) begin
          state_d = ST_WAIT_FALL;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_WAIT_FALL: begin
        if (!out_valid) begin
          grp_d   = grp_q + 16'd1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q >= GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      full_q     <= '0;
      fill_ptr_q <= 1'b0;
      fill_idx_q <= '0;
      iss_ptr_q  <= 1'b0;
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      tcnt_q     <= '0;
      gap_q      <= GAP_INIT;
      err_q      <= 1'b0;
      grp_q      <= '0;
    end else begin
      full_q     <= full_d;
      fill_ptr_q <= fill_ptr_d;
      fill_idx_q <= fill_idx_d;
      iss_ptr_q  <= iss_ptr_d;
      state_q    <= state_d;
      beat_q     <= beat_d;
      tcnt_q     <= tcnt_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      grp_q      <= grp_d;
    end
  end

  always_comb begin
    in_valid = (state_q == ST_ISSUE);
    in_data  = '0;
    in_mode  = '0;
    if (state_q == ST_ISSUE) begin
      in_data = bank_q[iss_ptr_q][beat_q];
      if (beat_q == '0) begin
        in_mode = mode_q[iss_ptr_q];
      end
    end
  end

  assign busy        = (state_q != ST_IDLE) | (|full_q) | (fill_idx_q != '0);
  assign timeout_err = err_q;
  assign grp_cnt     = grp_q;

endmodule
